// File: rtl/hexdump_line_formatter.sv
// Formats one (address, data) record as an ASCII hexdump line and feeds it
// character by character to a serial transmitter using its enable/word-finished handshake.
`timescale 1ns/1ps
module hexdump_line_formatter #(
    parameter int BITS       = 8,
    parameter int ADDR_WORDS = 3,
    parameter int ASCII_COL  = 1,
    parameter int UPPER_HEX  = 1
) (
    input  logic                       in_clk,
    input  logic                       in_rst_n,
    input  logic                       in_valid,
    output logic                       out_ready,
    input  logic [BITS*ADDR_WORDS-1:0] in_addr,
    input  logic [BITS-1:0]            in_data,
    output logic [7:0]                 out_char,
    output logic                       out_tx_enable,
    input  logic                       in_tx_word_finished,
    output logic                       out_line_done,
    output logic                       out_busy
);
    localparam int NDIG  = 2 * ADDR_WORDS;
    localparam int CNT_W = $clog2(NDIG) + 1;
    localparam int AW    = BITS * ADDR_WORDS;
    localparam logic [7:0] HEX_BASE = (UPPER_HEX != 0) ? 8'h37 : 8'h57;

    typedef enum logic [3:0] {
        S_IDLE, S_ADDR, S_COLON, S_SEP1, S_DHI, S_DLO, S_SEP2, S_ASCII, S_CR, S_LF
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [AW-1:0]    addr_q, addr_d;
    logic [BITS-1:0]  data_q, data_d;
    logic [7:0]       char_q, char_d;
    logic             en_q, en_d;
    logic             done_q, done_d;
    logic             ready_q, ready_d;
    logic             wf_q;
    logic             tx_step;

    function automatic logic [7:0] hex_char(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (HEX_BASE + {4'h0, n});
    endfunction

    // Digit counter 0 selects the most significant nibble of the address.
    function automatic logic [3:0] addr_nib(input logic [AW-1:0] a, input logic [CNT_W-1:0] c);
        logic [3:0] n;
        n = 4'h0;
        for (int i = 0; i < NDIG; i++) begin
            if (c == CNT_W'(NDIG - 1 - i)) n = a[4*i +: 4];
        end
        return n;
    endfunction

    function automatic logic [7:0] render(input state_t s, input logic [CNT_W-1:0] c,
                                          input logic [AW-1:0] a, input logic [BITS-1:0] d);
        logic [7:0] r;
        case (s)
            S_ADDR:  r = hex_char(addr_nib(a, c));
            S_COLON: r = 8'h3A;
            S_DHI:   r = hex_char(d[7:4]);
            S_DLO:   r = hex_char(d[3:0]);
            S_ASCII: r = (d[7:0] >= 8'h20 && d[7:0] <= 8'h7E) ? d[7:0] : 8'h2E;
            S_CR:    r = 8'h0D;
            S_LF:    r = 8'h0A;
            default: r = 8'h20;
        endcase
        return r;
    endfunction

    always_comb begin
        tx_step = in_tx_word_finished && !wf_q;
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        data_d  = data_q;
        done_d  = 1'b0;
        ready_d = ready_q;
        if (state_q == S_IDLE) begin
            ready_d = 1'b1;
            if (in_valid && ready_q) begin
                addr_d  = in_addr;
                data_d  = in_data;
                state_d = S_ADDR;
                cnt_d   = '0;
                ready_d = 1'b0;
            end
        end else if (tx_step) begin
            case (state_q)
                S_ADDR: begin
                    if (cnt_q == CNT_W'(NDIG - 1)) begin
                        state_d = S_COLON;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                S_COLON: state_d = S_SEP1;
                S_SEP1:  state_d = S_DHI;
                S_DHI:   state_d = S_DLO;
                S_DLO:   state_d = (ASCII_COL != 0) ? S_SEP2 : S_CR;
                S_SEP2:  state_d = S_ASCII;
                S_ASCII: state_d = S_CR;
                S_CR:    state_d = S_LF;
                S_LF: begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
                default: state_d = S_IDLE;
            endcase
        end
        // Enable drops for the single cycle following an accepted word-finished edge.
        en_d   = (state_d != S_IDLE) && !(tx_step && state_q != S_IDLE);
        char_d = render(state_d, cnt_d, addr_d, data_d);
    end

    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            char_q  <= 8'h20;
            en_q    <= 1'b0;
            done_q  <= 1'b0;
            ready_q <= 1'b1;
            wf_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            char_q  <= char_d;
            en_q    <= en_d;
            done_q  <= done_d;
            ready_q <= ready_d;
            wf_q    <= in_tx_word_finished;
        end
    end

    assign out_char      = char_q;
    assign out_tx_enable = en_q;
    assign out_line_done = done_q;
    assign out_ready     = ready_q;
    assign out_busy      = !ready_q;
endmodule

// File: tb/tb_hexdump_line_formatter.sv
// Bench for hexdump_line_formatter: three instances (defaults, short address without
// ASCII column, lowercase hex) driven by a transmitter model and a string-level line model.
`timescale 1ns/1ps
module tb_hexdump_line_formatter;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n = 1'b0;
    logic [2:0]  vld = '0;
    logic [2:0]  rdy, busy, en, done;
    logic [2:0]  wf = '0;
    logic [23:0] addr = '0;
    logic [7:0]  data = '0;
    logic [7:0]  ch [3];

    int n_chk = 0;
    int n_fail = 0;
    int hold_len = 1;
    localparam int DLY = 2;
    localparam int AWK [3] = '{3, 2, 3};
    localparam int ASCK[3] = '{1, 0, 1};
    localparam int UPK [3] = '{1, 1, 0};

    bit    active[3] = '{default: 0};
    bit    js[3]     = '{default: 0};
    int    pos[3]    = '{default: 0};
    int    ph[3]     = '{default: 0};
    int    cnt[3]    = '{default: 0};
    string exp_s[3];
    string cap[3];
    string last_line[3];
    string prev_line[3];

    hexdump_line_formatter #(.BITS(8), .ADDR_WORDS(3), .ASCII_COL(1), .UPPER_HEX(1)) dut0 (
        .in_clk(clk), .in_rst_n(rst_n), .in_valid(vld[0]), .out_ready(rdy[0]),
        .in_addr(addr), .in_data(data), .out_char(ch[0]), .out_tx_enable(en[0]),
        .in_tx_word_finished(wf[0]), .out_line_done(done[0]), .out_busy(busy[0]));
    hexdump_line_formatter #(.BITS(8), .ADDR_WORDS(2), .ASCII_COL(0), .UPPER_HEX(1)) dut1 (
        .in_clk(clk), .in_rst_n(rst_n), .in_valid(vld[1]), .out_ready(rdy[1]),
        .in_addr(addr[15:0]), .in_data(data), .out_char(ch[1]), .out_tx_enable(en[1]),
        .in_tx_word_finished(wf[1]), .out_line_done(done[1]), .out_busy(busy[1]));
    hexdump_line_formatter #(.BITS(8), .ADDR_WORDS(3), .ASCII_COL(1), .UPPER_HEX(0)) dut2 (
        .in_clk(clk), .in_rst_n(rst_n), .in_valid(vld[2]), .out_ready(rdy[2]),
        .in_addr(addr), .in_data(data), .out_char(ch[2]), .out_tx_enable(en[2]),
        .in_tx_word_finished(wf[2]), .out_line_done(done[2]), .out_busy(busy[2]));

    function automatic string vis(input string s);
        string r;
        r = "";
        for (int i = 0; i < s.len(); i++)
            r = (s[i] == 8'h0D) ? {r, "<CR>"} : (s[i] == 8'h0A) ? {r, "<LF>"} : $sformatf("%s%c", r, s[i]);
        return r;
    endfunction

    task automatic chk_i(input string nm, input longint act, input longint req);
        n_chk++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, req, $time);
        end
    endtask

    task automatic chk_s(input string nm, input string act, input string req);
        n_chk++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got \"%s\", expected \"%s\"", nm, vis(act), vis(req));
        end
    endtask

    task automatic timeout(input string nm);
        n_chk++;
        n_fail++;
        $display("FAIL %s: timed out waiting for the DUT", nm);
    endtask

    // Expected text of one line, built directly from the record.
    function automatic string line_str(input int aw, input int ascol, input int up,
                                       input logic [23:0] a, input logic [7:0] d);
        string hx, s;
        byte   c;
        int    nib;
        hx = (up != 0) ? "0123456789ABCDEF" : "0123456789abcdef";
        s  = "";
        for (int i = 2 * aw - 1; i >= 0; i--) begin
            nib = int'((a >> (4 * i)) & 24'hF);
            s   = $sformatf("%s%c", s, hx[nib]);
        end
        s = $sformatf("%s: %c%c", s, hx[d[7:4]], hx[d[3:0]]);
        if (ascol != 0) begin
            c = (d >= 8'h20 && d <= 8'h7E) ? d : 8'h2E;
            s = $sformatf("%s %c", s, c);
        end
        return {s, "\015\012"};
    endfunction

    always @(negedge clk) begin
        bit raise, was_active;
        for (int k = 0; k < 3; k++) begin
            if (!rst_n) begin
                active[k] = 0; js[k] = 0; ph[k] = 0; cnt[k] = 0; cap[k] = "";
                wf[k] = 1'b0;
            end else begin
                raise      = 0;
                was_active = active[k];
                if (js[k]) begin
                    chk_i($sformatf("line_done%0d", k), done[k], pos[k] == exp_s[k].len());
                    chk_i($sformatf("enable_step%0d", k), en[k], 0);
                end else begin
                    chk_i($sformatf("line_done%0d", k), done[k], 0);
                    chk_i($sformatf("enable%0d", k), en[k], active[k]);
                    if (active[k])
                        chk_i($sformatf("char%0d_pos%0d", k, pos[k]), ch[k], exp_s[k][pos[k]]);
                end
                chk_i($sformatf("ready%0d", k), rdy[k], !active[k]);
                chk_i($sformatf("busy%0d", k), busy[k], active[k]);

                if (js[k] && pos[k] == exp_s[k].len()) begin
                    active[k]    = 0;
                    prev_line[k] = last_line[k];
                    last_line[k] = cap[k];
                end
                if (active[k]) begin
                    if (ph[k] == 1) begin
                        cnt[k]++;
                        if (cnt[k] >= hold_len) begin
                            wf[k] = 1'b0; ph[k] = 0; cnt[k] = 0;
                        end
                    end else if (en[k] && pos[k] < exp_s[k].len()) begin
                        cnt[k]++;
                        if (cnt[k] >= DLY) begin
                            cap[k] = $sformatf("%s%c", cap[k], ch[k]);
                            pos[k]++;
                            wf[k] = 1'b1; ph[k] = 1; cnt[k] = 0; raise = 1;
                        end
                    end
                end else begin
                    wf[k] = 1'b0; ph[k] = 0; cnt[k] = 0;
                end
                js[k] = raise;
                if (vld[k] && !was_active) begin
                    exp_s[k]  = line_str(AWK[k], ASCK[k], UPK[k], addr, data);
                    active[k] = 1; pos[k] = 0; cap[k] = ""; ph[k] = 0; cnt[k] = 0;
                end
            end
        end
    end

    task automatic send(input int k, input logic [23:0] a, input logic [7:0] d);
        int t;
        @(posedge clk); #1;
        addr = a; data = d; vld[k] = 1'b1;
        t = 0;
        forever begin
            @(negedge clk);
            if (rdy[k]) break;
            t++;
            if (t > 5000) begin
                timeout("send");
                break;
            end
        end
        @(posedge clk); #1;
        vld[k] = 1'b0;
    endtask

    task automatic wait_idle(input int k);
        int t;
        t = 0;
        @(negedge clk);
        while (active[k] && t < 20000) begin
            @(negedge clk);
            t++;
        end
        if (active[k]) timeout("wait_idle");
        repeat (2) @(negedge clk);
    endtask

    task automatic run_line(input int k, input logic [23:0] a, input logic [7:0] d,
                            input string lit, input string nm);
        send(k, a, d);
        wait_idle(k);
        chk_s(nm, last_line[k], lit);
    endtask

    initial begin
        int t;
        chk_s("model_pin_default", line_str(3, 1, 1, 24'h00ABCD, 8'h23), {"00ABCD: 23 #", "\015\012"});
        chk_s("model_pin_noascii", line_str(2, 0, 1, 24'h001F00, 8'h7E), {"1F00: 7E", "\015\012"});
        chk_s("model_pin_lower", line_str(3, 1, 0, 24'hABCDEF, 8'hFF), {"abcdef: ff .", "\015\012"});

        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            chk_i($sformatf("rst_enable%0d", k), en[k], 0);
            chk_i($sformatf("rst_char%0d", k), ch[k], 8'h20);
            chk_i($sformatf("rst_ready%0d", k), rdy[k], 1);
            chk_i($sformatf("rst_busy%0d", k), busy[k], 0);
            chk_i($sformatf("rst_done%0d", k), done[k], 0);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;

        run_line(0, 24'h00ABCD, 8'h23, {"00ABCD: 23 #", "\015\012"}, "line_abcd");
        chk_i("line_len14", last_line[0].len(), 14);
        run_line(0, 24'h000001, 8'h0A, {"000001: 0A .", "\015\012"}, "line_data0a");
        run_line(0, 24'h123456, 8'hFF, {"123456: FF .", "\015\012"}, "line_dataff");
        run_line(2, 24'hABCDEF, 8'hFF, {"abcdef: ff .", "\015\012"}, "line_lower");
        run_line(1, 24'h001F00, 8'h7E, {"1F00: 7E", "\015\012"}, "line_noascii");
        chk_i("line_len10", last_line[1].len(), 10);

        hold_len = 50;
        run_line(0, 24'hFEDCBA, 8'h41, {"FEDCBA: 41 A", "\015\012"}, "line_hold");
        hold_len = 1;

        send(0, 24'h000010, 8'h30);
        send(0, 24'h000020, 8'h7F);
        wait_idle(0);
        chk_s("busy_first_line", prev_line[0], {"000010: 30 0", "\015\012"});
        chk_s("busy_second_line", last_line[0], {"000020: 7F .", "\015\012"});

        send(0, 24'h00ABCD, 8'h5A);
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!(pos[0] == 8 && en[0]) && t < 2000);
        if (t >= 2000) timeout("reach_datahi");
        #2;
        rst_n = 1'b0;
        #1;
        chk_i("async_rst_enable", en[0], 0);
        chk_i("async_rst_ready", rdy[0], 1);
        chk_i("async_rst_busy", busy[0], 0);
        repeat (2) @(negedge clk);
        @(posedge clk); #1;
        rst_n = 1'b1;
        run_line(0, 24'h000BAD, 8'h62, {"000BAD: 62 b", "\015\012"}, "line_after_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
